// File: rtl/mem_access_unit.sv
// mem_access_unit
//    Load/store initiator sitting between the EX/MEM pipeline register and a
//    word-only data RAM (combinational read, write on posedge when mem_we=1).
//    Byte and halfword stores are done as read-modify-write. Loads are lane
//    extracted and sign/zero extended. Misaligned, illegal-size and
//    out-of-range requests complete with resp_err and never touch the RAM.
//
// Ports
//    clk, clrn                  clock, synchronous active-low reset
//    req_valid / req_ready      request handshake (ready only while idle)
//    req_we, req_size, req_sign store/load, 00 byte 01 half 10 word, extension
//    req_addr, req_wdata        byte address, right-justified store data
//    resp_valid                 one-cycle completion pulse
//    resp_rdata, resp_err       load result / error flag, held until next accept
//    stall                      high while an access is in flight
//    mem_we, mem_addr,          RAM write enable, word-aligned address,
//    mem_wdata, mem_rdata       write data, combinational read data
module mem_access_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RMW_RD,
      S_WRITE,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] old_q, old_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        req_bad;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] store_word;

   // Any one of these sends the request straight to RESP with an error.
   always_comb begin
      req_bad = (req_size == 2'b11)
             || ((req_size == 2'b01) && req_addr[0])
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
             || (req_addr >= ADDR_LIMIT);
   end

   // Little-endian lane extraction from the word currently on mem_rdata.
   always_comb begin
      byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   // Word stores bypass the old word; sub-word stores patch their lane(s)
   // into the word captured during RMW_RD.
   always_comb begin
      store_word = old_q;
      case (size_q)
         2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: store_word = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      sign_d  = sign_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      old_d   = old_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               size_d  = req_size;
               sign_d  = req_sign;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = 32'h0;
               err_d   = req_bad;
               if (req_bad) begin
                  state_d = S_RESP;
               end else if (!req_we) begin
                  state_d = S_LOAD;
               end else if (req_size == 2'b10) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_RMW_RD;
               end
            end
         end
         S_LOAD: begin
            rdata_d = load_ext;
            state_d = S_RESP;
         end
         S_RMW_RD: begin
            old_d   = mem_rdata;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         size_q  <= 2'b00;
         sign_q  <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         old_q   <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         old_q   <= old_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign stall      = (state_q != S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   // Gating with clrn lets a reset landing on the WRITE cycle cancel the write.
   assign mem_we     = (state_q == S_WRITE) & clrn;
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_wdata  = (state_q == S_WRITE) ? store_word : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//    Drives mem_access_unit against a bench-side word RAM. A transaction-level
//    model predicts, for every accepted request, its completion cycle, result
//    and RAM effect; a per-cycle compare process checks all DUT outputs
//    against that timeline. Directed cases pin the model with literal values.
module tb_mem_access_unit;

   localparam int MEM_WORDS = 32;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_sign = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_sign   (req_sign),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .stall      (stall),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Word RAM: combinational read, write on posedge.
   logic [31:0] ram [MEM_WORDS];
   assign mem_rdata = ram[mem_addr[6:2]];
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'h0;
      forever begin
         @(posedge clk);
         if (mem_we) ram[mem_addr[6:2]] <= mem_wdata;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- transaction-level model ----------------
   // Cycle e is the interval that begins at posedge number e.
   int          e        = 0;
   int          ready_at = 0;     // first cycle the unit is idle again
   int          resp_at  = -10;   // cycle in which resp_valid must be high
   logic        pend     = 1'b0;
   logic        pend_w   = 1'b0;
   int          pend_idx = 0;
   logic [31:0] pend_word  = 32'h0;
   logic [31:0] pend_rdata = 32'h0;
   logic [31:0] exp_rdata_h = 32'h0;
   logic        exp_err_h   = 1'b0;
   logic [31:0] exp_addr_h  = 32'h0;
   logic [31:0] model_ram [MEM_WORDS];

   initial begin
      int          lane;
      int          lat;
      logic [31:0] w;
      logic [31:0] v;
      logic [31:0] mask;
      logic        bad;
      for (int i = 0; i < MEM_WORDS; i++) model_ram[i] = 32'h0;
      forever begin
         @(posedge clk);
         e++;
         if (!clrn) begin
            pend        = 1'b0;
            ready_at    = e;
            exp_rdata_h = 32'h0;
            exp_err_h   = 1'b0;
            exp_addr_h  = 32'h0;
         end else begin
            if (pend && e == resp_at) begin
               if (pend_w) model_ram[pend_idx] = pend_word;
               exp_rdata_h = pend_rdata;
            end
            if (pend && e > resp_at) pend = 1'b0;
            if (req_valid && (e - 1) >= ready_at) begin
               lane = int'(req_addr[1:0]);
               w    = model_ram[req_addr[6:2]];
               bad  = (req_size == 2'd3)
                   || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && req_addr[1:0] != 2'd0)
                   || (req_addr >= 32'(4 * MEM_WORDS));
               pend        = 1'b1;
               pend_w      = 1'b0;
               pend_rdata  = 32'h0;
               pend_word   = 32'h0;
               pend_idx    = int'(req_addr[6:2]);
               exp_addr_h  = req_addr & ~32'h3;
               exp_rdata_h = 32'h0;
               exp_err_h   = bad;
               if (bad) begin
                  lat = 1;
               end else if (!req_we) begin
                  lat = 2;
                  if (req_size == 2'd0) begin
                     v = (w >> (8 * lane)) & 32'hFF;
                     if (req_sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
                  end else if (req_size == 2'd1) begin
                     v = (w >> (8 * lane)) & 32'hFFFF;
                     if (req_sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
                  end else begin
                     v = w;
                  end
                  pend_rdata = v;
               end else begin
                  pend_w = 1'b1;
                  if (req_size == 2'd2) begin
                     lat       = 2;
                     pend_word = req_wdata;
                  end else begin
                     lat       = 3;
                     mask      = ((req_size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * lane);
                     pend_word = (w & ~mask) | ((req_wdata << (8 * lane)) & mask);
                  end
               end
               resp_at  = (e - 1) + lat;
               ready_at = resp_at + 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic chk_en  = 1'b0;
   logic we_seen = 1'b0;
   logic rv_seen = 1'b0;

   initial begin
      logic exp_rdy;
      logic exp_rv;
      logic exp_wcyc;
      int   bad_words;
      forever begin
         @(negedge clk);
         if (mem_we) we_seen = 1'b1;
         if (resp_valid) rv_seen = 1'b1;
         if (chk_en) begin
            exp_rdy  = (e >= ready_at);
            exp_rv   = pend && (e == resp_at);
            exp_wcyc = pend && pend_w && (e == resp_at - 1);
            chk1("req_ready", req_ready, exp_rdy);
            chk1("stall", stall, !exp_rdy);
            chk1("resp_valid", resp_valid, exp_rv);
            chk1("resp_err", resp_err, exp_err_h);
            chk32("resp_rdata", resp_rdata, exp_rdata_h);
            chk1("mem_we", mem_we, exp_wcyc && clrn);
            chk32("mem_addr", mem_addr, exp_addr_h);
            chk32("mem_wdata", mem_wdata, exp_wcyc ? pend_word : 32'h0);
            if (exp_rv) begin
               bad_words = 0;
               for (int i = 0; i < MEM_WORDS; i++)
                  if (ram[i] !== model_ram[i]) bad_words++;
               chk_int("ram_image", bad_words, 0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, wait for acceptance and completion (both bounded).
   // lat = cycles from the accept cycle to the resp_valid cycle.
   task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
      int n;
      req_valid = 1'b1;
      req_we    = we;
      req_size  = sz;
      req_sign  = sg;
      req_addr  = a;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         tick();
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
   endtask

   task automatic directed(input string name, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
      logic [31:0] rd;
      logic        er;
      int          lat;
      issue(we, sz, sg, a, wd, rd, er, lat);
      chk32({name, "_rdata"}, rd, exp_rd);
      chk1({name, "_err"}, er, exp_er);
      chk_int({name, "_latency"}, lat, exp_lat);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          n;
      int          acc [3];
      logic        we;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;

      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      clrn   = 1'b1;

      // reset state
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk1("rst_resp_err", resp_err, 1'b0);
      chk32("rst_resp_rdata", resp_rdata, 32'h0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);

      // word store / word load
      directed("sw_08", 1'b1, 2'd2, 1'b0, 32'h08, 32'h1234_5678, 32'h0, 1'b0, 2);
      chk32("sw_08_ram2", ram[2], 32'h1234_5678);
      directed("lw_08", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0, 2);

      // byte store via RMW, signed/unsigned byte loads
      directed("sw_04", 1'b1, 2'd2, 1'b0, 32'h04, 32'h0000_000A, 32'h0, 1'b0, 2);
      directed("sb_06", 1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_00FF, 32'h0, 1'b0, 3);
      chk32("sb_06_ram1", ram[1], 32'h00FF_000A);
      directed("lb_06", 1'b0, 2'd0, 1'b1, 32'h06, 32'h0, 32'hFFFF_FFFF, 1'b0, 2);
      directed("lbu_06", 1'b0, 2'd0, 1'b0, 32'h06, 32'h0, 32'h0000_00FF, 1'b0, 2);

      // half store onto zero word, signed/unsigned half loads
      directed("sh_0e", 1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000_8001, 32'h0, 1'b0, 3);
      chk32("sh_0e_ram3", ram[3], 32'h8001_0000);
      directed("lh_0e", 1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 32'hFFFF_8001, 1'b0, 2);
      directed("lhu_0e", 1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, 32'h0000_8001, 1'b0, 2);

      // error cases: no RAM write, one-cycle latency, zero data
      we_seen = 1'b0;
      directed("err_lw_05", 1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1, 1);
      directed("err_sh_03", 1'b1, 2'd1, 1'b0, 32'h03, 32'hBEEF, 32'h0, 1'b1, 1);
      directed("err_size3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
      directed("err_lw_80", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 1);
      chk1("err_no_mem_we", we_seen, 1'b0);
      chk32("err_ram1", ram[1], 32'h00FF_000A);
      chk32("err_ram2", ram[2], 32'h1234_5678);
      chk32("err_ram3", ram[3], 32'h8001_0000);

      // reset landing on the WRITE cycle of a byte store
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd0;
      req_sign  = 1'b0;
      req_addr  = 32'h04;
      req_wdata = 32'h0000_0055;
      n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      tick();                 // accepted; RMW_RD
      req_valid = 1'b0;
      tick();                 // WRITE
      chk1("abort_in_write", mem_we, 1'b1);
      clrn = 1'b0;
      rv_seen = 1'b0;
      tick();
      clrn = 1'b1;
      chk1("abort_stall", stall, 1'b0);
      chk1("abort_ready", req_ready, 1'b1);
      repeat (4) tick();
      chk1("abort_no_resp", rv_seen, 1'b0);
      chk32("abort_ram1", ram[1], 32'h00FF_000A);

      // request held high across three word stores
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_sign  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_addr  = 32'h20 + 32'(4 * i);
         req_wdata = 32'hA000_0000 + 32'(i + 1);
         n = 0;
         while (!req_ready && n < 50) begin
            tick();
            n++;
         end
         tick();
         acc[i] = e;
      end
      req_valid = 1'b0;
      repeat (3) tick();
      chk_int("b2b_gap1", acc[1] - acc[0], 3);
      chk_int("b2b_gap2", acc[2] - acc[1], 3);
      chk32("b2b_ram8", ram[8], 32'hA000_0001);
      chk32("b2b_ram9", ram[9], 32'hA000_0002);
      chk32("b2b_ram10", ram[10], 32'hA000_0003);

      // randomized traffic, checked cycle by cycle by the model
      for (int t = 0; t < 300; t++) begin
         we = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         sz = (r < 9) ? 2'(r % 3) : 2'd3;
         r  = int'($urandom_range(0, 15));
         if (r == 0) begin
            a = 32'd128 + 32'($urandom_range(0, 4096));
         end else if (r == 1) begin
            a = $urandom;
         end else begin
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
               if (sz == 2'd1) a[0] = 1'b0;
               else if (sz == 2'd2) a[1:0] = 2'b00;
            end
         end
         issue(we, sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er, lat);
         repeat (int'($urandom_range(0, 2))) tick();
      end

      repeat (4) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
